// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter: FSM state
// encoding, ALU control bit positions and the common op codes.
package alu_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bit positions inside the op field {zx,nx,zy,ny,f,no}.
  localparam int OP_ZX = 5;
  localparam int OP_NX = 4;
  localparam int OP_ZY = 3;
  localparam int OP_NY = 2;
  localparam int OP_F  = 1;
  localparam int OP_NO = 0;

  localparam logic [OP_W-1:0] OP_AND  = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADD  = 6'b000010;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b010011;
  localparam logic [OP_W-1:0] OP_ZERO = 6'b101010;
  localparam logic [OP_W-1:0] OP_ONE  = 6'b111111;
  localparam logic [OP_W-1:0] OP_NEG1 = 6'b111010;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational two-way picker: round-robin against last_grant, or fixed
// priority to requester 0 when FIXED_PRIO is set.
module alu_rr_pick #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  // On a tie requester 0 wins if it did not win last time (or always, fixed).
  assign grant0 = valid0 && (!valid1 || FIXED_PRIO || last_grant);
  assign grant1 = valid1 && (!valid0 || (!FIXED_PRIO && !last_grant));

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external 16-bit ALU between two valid/ready requesters, one op in
// flight at a time. Define ALU_ARB_FLAGS_EN to add the zero/negative flags.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,

  output logic              alu_enable,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic              rsp0_zr,
  output logic              rsp0_ng,
  output logic              rsp1_zr,
  output logic              rsp1_ng
`endif
);

  state_e              state_q;
  logic                last_grant_q;
  logic                owner_q;
  logic                alu_en_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   x_q;
  logic [DATA_W-1:0]   y_q;
  logic [DATA_W-1:0]   res_q;
  logic [1:0]          rsp_valid_q;
  logic                grant0;
  logic                grant1;
  logic                in_idle;
`ifdef ALU_ARB_FLAGS_EN
  logic                zr_q;
  logic                ng_q;
`endif

  alu_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // NOTE: rst_n gates ready so that every output is 0 while reset is applied.
  assign in_idle    = rst_n && (state_q == IDLE);
  assign req0_ready = in_idle && grant0;
  assign req1_ready = in_idle && grant1;

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_en_q     <= 1'b0;
      op_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      res_q        <= '0;
      rsp_valid_q  <= '0;
`ifdef ALU_ARB_FLAGS_EN
      zr_q         <= 1'b0;
      ng_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            owner_q      <= grant1;
            last_grant_q <= grant1;
            op_q         <= grant1 ? req1_op : req0_op;
            x_q          <= grant1 ? req1_x  : req0_x;
            y_q          <= grant1 ? req1_y  : req0_y;
            alu_en_q     <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          // Operand registers double as the ALU drive, so clearing them zeroes alu_*.
          res_q                <= alu_out;
          rsp_valid_q[owner_q] <= 1'b1;
          alu_en_q             <= 1'b0;
          op_q                 <= '0;
          x_q                  <= '0;
          y_q                  <= '0;
`ifdef ALU_ARB_FLAGS_EN
          zr_q                 <= (alu_out == '0);
          ng_q                 <= alu_out[DATA_W-1];
`endif
          state_q              <= RESP;
        end
        RESP: begin
          if (owner_q ? rsp1_ready : rsp0_ready) begin
            rsp_valid_q <= '0;
            res_q       <= '0;
`ifdef ALU_ARB_FLAGS_EN
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_enable = alu_en_q;
  assign alu_zx     = op_q[OP_ZX];
  assign alu_nx     = op_q[OP_NX];
  assign alu_zy     = op_q[OP_ZY];
  assign alu_ny     = op_q[OP_NY];
  assign alu_f      = op_q[OP_F];
  assign alu_no     = op_q[OP_NO];
  assign alu_x      = x_q;
  assign alu_y      = y_q;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_valid_q[0] ? res_q : '0;
  assign rsp1_data  = rsp_valid_q[1] ? res_q : '0;
`ifdef ALU_ARB_FLAGS_EN
  assign rsp0_zr    = rsp_valid_q[0] && zr_q;
  assign rsp0_ng    = rsp_valid_q[0] && ng_q;
  assign rsp1_zr    = rsp_valid_q[1] && zr_q;
  assign rsp1_ng    = rsp_valid_q[1] && ng_q;
`endif

endmodule
